fpvecpack: RTL and testbench

Stream-to-vector packer that sits in front of the floating-point adder tree. It accepts one DW-bit floating-point word per cycle and assembles TW words into the packed input vector the tree consumes. It zero-pads short vectors terminated by a last marker. It also carries a valid/last/count tag through a delay line matched to the tree latency, so downstream logic knows which tree output cycle holds a real sum.

---
 rtl/fpvecpack_if.sv | 29 ++
 rtl/fpvecpack.sv | 112 +++++++++++
 tb/tb_fpvecpack.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpvecpack_if.sv
// Stream-in / vector-out bundle between the word source, the packer and the adder tree.
// master drives words in and consumes vectors and tags; slave is the packer.
interface fpvecpack_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned TW = 16
);
   localparam int unsigned NW = $clog2(TW + 1);

   logic              in_vld;
   logic              in_rdy;
   logic [DW-1:0]     in_dat;
   logic              in_lst;
   logic [TW*DW-1:0]  x;
   logic              x_vld;
   logic [NW-1:0]     x_n;
   logic              r_vld;
   logic              r_lst;
   logic [NW-1:0]     r_n;

   modport master (
      output in_vld, in_dat, in_lst,
      input  in_rdy, x, x_vld, x_n, r_vld, r_lst, r_n
   );

   modport slave (
      input  in_vld, in_dat, in_lst,
      output in_rdy, x, x_vld, x_n, r_vld, r_lst, r_n
   );
endinterface

// File: rtl/fpvecpack.sv
// Packs a stream of fp words into TW-wide zero-padded vectors for the adder tree and
// carries a {vld, lst, n} tag through a delay line matched to the tree latency.
module fpvecpack #(
   parameter int unsigned DW = 32,
   parameter int unsigned TW = 16,
   parameter int unsigned TL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   fpvecpack_if.slave bus
);
   localparam int unsigned CW = $clog2(TW);
   localparam int unsigned NW = $clog2(TW + 1);

   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

   typedef struct packed {
      logic          vld;
      logic          lst;
      logic [NW-1:0] n;
   } tag_t;

   state_t            state, state_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic [DW-1:0]     sbuf   [TW];
   logic [DW-1:0]     sbuf_d [TW];
   logic [TW*DW-1:0]  x_q, x_d;
   logic              x_vld_q, x_vld_d;
   logic [NW-1:0]     x_n_q, x_n_d;
   logic              x_lst_q, x_lst_d;
   tag_t              dly [TL];
   logic              acc;
   logic              done;

   // Next state, buffer write and vector completion
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      sbuf_d  = sbuf;
      x_d     = x_q;
      x_vld_d = x_vld_q;
      x_n_d   = x_n_q;
      x_lst_d = x_lst_q;
      acc     = bus.in_vld & ena;
      done    = acc & (bus.in_lst | (cnt == CW'(TW - 1)));

      if (ena) x_vld_d = 1'b0;

      if (done) begin
         // Slots above cnt are already zero in the buffer, so they pad with +0.0
         for (int k = 0; k < int'(TW); k++)
            x_d[k*DW +: DW] = (k == int'(cnt)) ? bus.in_dat : sbuf[k];
         x_vld_d = 1'b1;
         x_n_d   = NW'(cnt) + NW'(1);
         x_lst_d = bus.in_lst;
         for (int k = 0; k < int'(TW); k++)
            sbuf_d[k] = '0;
         cnt_d = '0;
      end else if (acc) begin
         sbuf_d[cnt] = bus.in_dat;
         cnt_d       = cnt + CW'(1);
      end

      case (state)
         IDLE:    if (acc && !done) state_d = FILL;
         FILL:    if (done)         state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         x_q     <= '0;
         x_vld_q <= 1'b0;
         x_n_q   <= '0;
         x_lst_q <= 1'b0;
         for (int k = 0; k < int'(TW); k++)
            sbuf[k] <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         x_q     <= x_d;
         x_vld_q <= x_vld_d;
         x_n_q   <= x_n_d;
         x_lst_q <= x_lst_d;
         sbuf    <= sbuf_d;
      end
   end

   // Tag delay line advances only with the tree pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(TL); i++)
            dly[i] <= '0;
      end else if (ena) begin
         dly[0] <= {x_vld_q, x_lst_q, x_n_q};
         for (int i = 1; i < int'(TL); i++)
            dly[i] <= dly[i-1];
      end
   end

   assign bus.in_rdy = ena;
   assign bus.x      = x_q;
   assign bus.x_vld  = x_vld_q;
   assign bus.x_n    = x_n_q;
   assign bus.r_vld  = dly[TL-1].vld;
   assign bus.r_lst  = dly[TL-1].lst;
   assign bus.r_n    = dly[TL-1].n;
endmodule

// File: tb/tb_fpvecpack.sv
// Self-checking bench for fpvecpack: directed vector table, hand sequences for stalls,
// back-to-back vectors and mid-fill reset, then random traffic against a history model.
module tb_fpvecpack;
   localparam int unsigned DW = 32;
   localparam int unsigned TW = 16;
   localparam int unsigned TL = 4;

   typedef struct {
      bit               vld;
      bit               lst;
      int unsigned      n;
      logic [TW*DW-1:0] vec;
   } snap_t;

   typedef struct {
      int unsigned   len;
      bit            lst;
      logic [DW-1:0] dat0;
      logic [DW-1:0] stp;
      int unsigned   exp_n;
      bit            exp_lst;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic ena;

   fpvecpack_if #(.DW(DW), .TW(TW)) bus();

   fpvecpack #(.DW(DW), .TW(TW), .TL(TL)) dut (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned passed = 0;
   int unsigned cyc    = 0;

   // Model: snapshot of expected outputs after each enabled edge since reset
   snap_t         hist[$];
   logic [DW-1:0] words[$];

   function automatic snap_t zero_snap();
      snap_t s;
      s.vld = 1'b0;
      s.lst = 1'b0;
      s.n   = 0;
      s.vec = '0;
      return s;
   endfunction

   function automatic void model_clear();
      hist.delete();
      hist.push_back(zero_snap());
      words.delete();
   endfunction

   function automatic void model_edge(bit vld, logic [DW-1:0] dat, bit lst);
      snap_t s;
      s = hist[hist.size()-1];
      s.vld = 1'b0;
      if (vld) begin
         words.push_back(dat);
         if (words.size() == TW || lst) begin
            s.vld = 1'b1;
            s.lst = lst;
            s.n   = words.size();
            s.vec = '0;
            foreach (words[i]) s.vec[i*DW +: DW] = words[i];
            words.delete();
         end
      end
      hist.push_back(s);
   endfunction

   task automatic chk(string name, logic [TW*DW-1:0] act, logic [TW*DW-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check_all();
      snap_t c;
      snap_t r;
      int    ri;
      c  = hist[hist.size()-1];
      ri = int'(hist.size()) - 1 - int'(TL);
      r  = hist[(ri < 0) ? 0 : ri];
      chk("in_rdy", bus.in_rdy, ena);
      chk("x_vld", bus.x_vld, c.vld);
      chk("x_n", bus.x_n, c.n);
      chk("x", bus.x, c.vec);
      chk("r_vld", bus.r_vld, r.vld);
      chk("r_lst", bus.r_lst, r.lst);
      chk("r_n", bus.r_n, r.n);
   endtask

   task automatic tick(bit en, bit vld, logic [DW-1:0] dat, bit lst);
      ena        = en;
      bus.in_vld = vld;
      bus.in_dat = dat;
      bus.in_lst = lst;
      if (en) model_edge(vld, dat, lst);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_all();
   endtask

   task automatic idle(int unsigned n);
      for (int i = 0; i < int'(n); i++) tick(1'b1, 1'b0, '0, 1'b0);
   endtask

   // Asserted between edges so the asynchronous clear is observable before any clock
   task automatic do_reset();
      ena        = 1'b0;
      bus.in_vld = 1'b0;
      bus.in_dat = '0;
      bus.in_lst = 1'b0;
      rst        = 1'b1;
      #1;
      model_clear();
      check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t tbl[5];

   initial begin
      int unsigned      pulses;
      int unsigned      xcyc;
      int unsigned      rcyc;
      int unsigned      xn_seen;
      bit               rlst_seen;
      logic [TW*DW-1:0] x_seen;
      logic [TW*DW-1:0] x_want;
      int unsigned      pc[$];
      logic [TW*DW-1:0] px[$];
      int unsigned      c0;

      tbl[0] = '{len: 16, lst: 1'b0, dat0: 32'h3F80_0000, stp: 32'h0,         exp_n: 16, exp_lst: 1'b0};
      tbl[1] = '{len: 3,  lst: 1'b1, dat0: 32'h4000_0000, stp: 32'h0040_0000, exp_n: 3,  exp_lst: 1'b1};
      tbl[2] = '{len: 16, lst: 1'b1, dat0: 32'h4100_0000, stp: 32'h1,         exp_n: 16, exp_lst: 1'b1};
      tbl[3] = '{len: 1,  lst: 1'b1, dat0: 32'hC0A0_0000, stp: 32'h0,         exp_n: 1,  exp_lst: 1'b1};
      tbl[4] = '{len: 15, lst: 1'b1, dat0: 32'h3F00_0000, stp: 32'h10,        exp_n: 15, exp_lst: 1'b1};

      rst        = 1'b1;
      ena        = 1'b0;
      bus.in_vld = 1'b0;
      bus.in_dat = '0;
      bus.in_lst = 1'b0;
      #1;
      model_clear();
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors with fixed expectations
      for (int v = 0; v < 5; v++) begin
         pulses = 0; xcyc = 0; rcyc = 0; xn_seen = 0; rlst_seen = 1'b0; x_seen = '0;
         x_want = '0;
         for (int k = 0; k < int'(tbl[v].len); k++)
            x_want[k*DW +: DW] = tbl[v].dat0 + DW'(k) * tbl[v].stp;
         for (int k = 0; k < int'(TW + TL + 3); k++) begin
            if (k < int'(tbl[v].len))
               tick(1'b1, 1'b1, tbl[v].dat0 + DW'(k) * tbl[v].stp,
                    tbl[v].lst && (k == int'(tbl[v].len) - 1));
            else
               tick(1'b1, 1'b0, '0, 1'b0);
            if (bus.x_vld) begin
               pulses++; xcyc = cyc; xn_seen = bus.x_n; x_seen = bus.x;
            end
            if (bus.r_vld) begin
               rcyc = cyc; rlst_seen = bus.r_lst;
            end
         end
         chk("tbl_pulses", pulses, 1);
         chk("tbl_x_n", xn_seen, tbl[v].exp_n);
         chk("tbl_x", x_seen, x_want);
         chk("tbl_r_lst", rlst_seen, tbl[v].exp_lst);
         chk("tbl_r_delay", rcyc - xcyc, TL);
      end

      // Two full vectors streamed with no gap
      pc.delete(); px.delete();
      for (int k = 0; k < int'(2 * TW + TL + 2); k++) begin
         if (k < int'(2 * TW)) tick(1'b1, 1'b1, DW'(32'h100 + k), 1'b0);
         else                  tick(1'b1, 1'b0, '0, 1'b0);
         if (bus.x_vld) begin
            pc.push_back(cyc); px.push_back(bus.x);
         end
      end
      chk("b2b_pulses", pc.size(), 2);
      if (pc.size() == 2) begin
         chk("b2b_spacing", pc[1] - pc[0], TW);
         chk("b2b_slot0", px[1][DW-1:0], DW'(32'h100 + TW));
      end

      // ena low for 5 cycles after the 7th word with in_vld held high
      pulses = 0; xcyc = 0; rcyc = 0;
      c0 = cyc;
      for (int k = 0; k < 7; k++) tick(1'b1, 1'b1, DW'(32'h200 + k), 1'b0);
      for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      for (int k = 7; k < int'(TW); k++) tick(1'b1, 1'b1, DW'(32'h200 + k), 1'b0);
      for (int k = 0; k < int'(TL + 2); k++) begin
         if (bus.x_vld) begin pulses++; xcyc = cyc; end
         tick(1'b1, 1'b0, '0, 1'b0);
         if (bus.r_vld) rcyc = cyc;
      end
      chk("stall_pulses", pulses, 1);
      chk("stall_latency", xcyc - c0, TW + 5);
      chk("stall_r_delay", rcyc - xcyc, TL);

      // ena low while x_vld is high: pulse held, then consumed by the next enabled edge
      tick(1'b1, 1'b1, 32'h4040_0000, 1'b0);
      tick(1'b1, 1'b1, 32'h4080_0000, 1'b1);
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, '0, 1'b0);
      chk("hold_x_vld", bus.x_vld, 1'b1);
      tick(1'b1, 1'b0, '0, 1'b0);
      chk("hold_x_vld_clr", bus.x_vld, 1'b0);
      idle(TL + 1);

      // Reset mid-fill discards the partial vector and in-flight tags
      tick(1'b1, 1'b1, 32'h3F80_0000, 1'b1);
      for (int k = 0; k < 9; k++) tick(1'b1, 1'b1, DW'(32'hBAD0 + k), 1'b0);
      do_reset();
      chk("rst_x", bus.x, '0);
      chk("rst_r_vld", bus.r_vld, 1'b0);
      pulses = 0; x_want = '0;
      for (int k = 0; k < int'(TW); k++) x_want[k*DW +: DW] = DW'(32'h1000 + k);
      for (int k = 0; k < int'(TW + TL + 2); k++) begin
         if (k < int'(TW)) tick(1'b1, 1'b1, DW'(32'h1000 + k), 1'b0);
         else              tick(1'b1, 1'b0, '0, 1'b0);
         if (bus.x_vld) begin pulses++; x_seen = bus.x; end
      end
      chk("rst_pulses", pulses, 1);
      chk("rst_fresh_x", x_seen, x_want);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++)
         tick($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 70, $urandom(),
              $urandom_range(0, 99) < 15);
      idle(TL + 2);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
